// File: rtl/l2_pkg.sv
// Shared types, address helpers and command priority for the L2 write-side fill controller.
// Word addresses are [27:2]; a line is 4 words, so the word index is address bits [3:2].
package l2_pkg;

    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 26;
    localparam int IDX_W      = 2;
    localparam int TAG_W      = ADDR_W - IDX_W;

    typedef logic [ADDR_W-1:0] waddr_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ACK
    } state_t;

    // Cache-port commands, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_WORD,
        CMD_SNOOP,
        CMD_INV,
        CMD_FLUSH
    } cmd_t;

    function automatic cmd_t pick_cmd(input logic flush, input logic inv,
                                      input logic snp, input logic word);
        cmd_t c;
        if (flush)
            c = CMD_FLUSH;
        else if (inv)
            c = CMD_INV;
        else if (snp)
            c = CMD_SNOOP;
        else if (word)
            c = CMD_WORD;
        else
            c = CMD_NONE;
        return c;
    endfunction

    function automatic waddr_t line_base(input waddr_t a);
        return a & ~waddr_t'(LINE_WORDS - 1);
    endfunction

    function automatic logic same_line(input waddr_t a, input waddr_t b);
        return line_base(a) == line_base(b);
    endfunction

    function automatic waddr_t word_addr(input waddr_t base, input idx_t idx);
        return base | waddr_t'(idx);
    endfunction

endpackage

// File: rtl/l2_fill_buf.sv
// One-entry buffer for the memory word awaiting its cache write, plus the per-word byte
// exclusion masks that stop fill data from overwriting bytes the CPU wrote during the fill.
module l2_fill_buf
    import l2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        drain,
    input  logic        excl_set,
    input  logic [1:0]  excl_idx,
    input  logic [3:0]  excl_mask,
    input  logic [1:0]  rd_idx,
    output logic        full,
    output logic [31:0] data,
    output logic [3:0]  mask
);

    logic [LINE_WORDS-1:0][3:0] excl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            excl <= '0;
        end else if (clear) begin
            excl <= '0;
        end else if (excl_set) begin
            excl[excl_idx] <= excl[excl_idx] | excl_mask;
        end
    end

    assign mask = 4'hF & ~excl[rd_idx];

endmodule

// File: rtl/l2_fill_ctrl.sv
// Write-side L2 controller: line fills on read misses, write-through of snooped CPU writes,
// and single/global invalidates, arbitrated onto one registered cache write port.
module l2_fill_ctrl
    import l2_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        MissReq,
    input  logic [27:2] MissA,
    output logic        MissAck,
    output logic        MemReq,
    output logic [27:2] MemA,
    input  logic        MemAck,
    input  logic [31:0] MemD,
    input  logic        SnpWR,
    input  logic [27:2] SnpA,
    input  logic [31:0] SnpD,
    input  logic [3:0]  SnpM,
    input  logic        InvReq,
    input  logic [27:2] InvA,
    input  logic        FlushReq,
    output logic [27:2] WRA,
    output logic [31:0] WRD,
    output logic [3:0]  WRM,
    output logic        TS,
    output logic        WR,
    output logic        CLR,
    output logic        ALL,
    output logic        Busy
);

    state_t      state, state_nx;
    cmd_t        cmd;

    waddr_t      fill_base;
    logic [2:0]  rx_cnt;
    idx_t        wr_cnt;

    logic        pend_flush;
    logic        pend_inv;
    waddr_t      pend_inv_a;
    logic        pend_snp;
    waddr_t      pend_snp_a;
    logic [31:0] pend_snp_d;
    logic [3:0]  pend_snp_m;

    logic        flush_req, inv_req, snp_req, word_req;
    waddr_t      inv_a, snp_a;
    logic [31:0] snp_d;
    logic [3:0]  snp_m;

    logic        buf_full;
    logic [31:0] buf_data;
    logic [3:0]  buf_mask;
    logic        ack_ok, excl_set, buf_clear;

    logic        miss_go, abort;
    logic        mem_req_nx, miss_ack_nx, busy_nx;
    logic        wr_nx, ts_nx, clr_nx, all_nx;
    waddr_t      wra_nx;
    logic [31:0] wrd_nx;
    logic [3:0]  wrm_nx;

    // Pulse requests that lose arbitration wait in a pending slot; the older one is served first.
    always_comb begin
        flush_req = FlushReq | pend_flush;
        inv_req   = InvReq | pend_inv;
        inv_a     = pend_inv ? pend_inv_a : InvA;
        snp_req   = SnpWR | pend_snp;
        snp_a     = pend_snp ? pend_snp_a : SnpA;
        snp_d     = pend_snp ? pend_snp_d : SnpD;
        snp_m     = pend_snp ? pend_snp_m : SnpM;
        word_req  = (state == FILL) && buf_full;
        cmd       = pick_cmd(flush_req, inv_req, snp_req, word_req);
        ack_ok    = (state == FILL) && MemAck && !buf_full && (rx_cnt < 3'(LINE_WORDS));
        excl_set  = (cmd == CMD_SNOOP) && (state == FILL) && same_line(snp_a, fill_base);
    end

    always_comb begin
        state_nx    = state;
        mem_req_nx  = MemReq;
        miss_ack_nx = 1'b0;
        wr_nx       = 1'b0;
        ts_nx       = 1'b0;
        clr_nx      = 1'b0;
        all_nx      = 1'b0;
        wra_nx      = WRA;
        wrd_nx      = WRD;
        wrm_nx      = WRM;
        miss_go     = 1'b0;
        abort       = 1'b0;

        case (cmd)
            CMD_FLUSH: begin
                clr_nx = 1'b1;
                all_nx = 1'b1;
            end
            CMD_INV: begin
                clr_nx = 1'b1;
                wra_nx = inv_a;
            end
            CMD_SNOOP: begin
                wr_nx  = 1'b1;
                wra_nx = snp_a;
                wrd_nx = snp_d;
                wrm_nx = snp_m;
            end
            CMD_WORD: begin
                wr_nx  = 1'b1;
                ts_nx  = (wr_cnt == '0);
                wra_nx = word_addr(fill_base, wr_cnt);
                wrd_nx = buf_data;
                wrm_nx = buf_mask;
            end
            default: ;
        endcase

        // MissAck still high means the CPU has not yet dropped the request it just got acked.
        case (state)
            IDLE: begin
                if (cmd == CMD_NONE && MissReq && !MissAck) begin
                    state_nx   = FILL;
                    mem_req_nx = 1'b1;
                    miss_go    = 1'b1;
                end
            end
            FILL: begin
                if (cmd == CMD_FLUSH || cmd == CMD_INV) begin
                    abort      = 1'b1;
                    state_nx   = IDLE;
                    mem_req_nx = 1'b0;
                end else if (cmd == CMD_WORD && wr_cnt == idx_t'(LINE_WORDS - 1)) begin
                    state_nx   = ACK;
                    mem_req_nx = 1'b0;
                end
            end
            ACK: begin
                miss_ack_nx = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    assign buf_clear = miss_go | abort;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            MissAck <= 1'b0;
            MemReq  <= 1'b0;
            WR      <= 1'b0;
            TS      <= 1'b0;
            CLR     <= 1'b0;
            ALL     <= 1'b0;
            Busy    <= 1'b0;
            WRA     <= '0;
            WRD     <= '0;
            WRM     <= '0;
        end else begin
            MissAck <= miss_ack_nx;
            MemReq  <= mem_req_nx;
            WR      <= wr_nx;
            TS      <= ts_nx;
            CLR     <= clr_nx;
            ALL     <= all_nx;
            Busy    <= busy_nx;
            WRA     <= wra_nx;
            WRD     <= wrd_nx;
            WRM     <= wrm_nx;
        end
    end

    // The burst is line-aligned; MemA advances on each accepted beat and parks on the last word.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fill_base <= '0;
            MemA      <= '0;
            rx_cnt    <= '0;
            wr_cnt    <= '0;
        end else if (miss_go) begin
            fill_base <= line_base(MissA);
            MemA      <= line_base(MissA);
            rx_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            if (ack_ok) begin
                rx_cnt <= rx_cnt + 3'd1;
                if (rx_cnt < 3'(LINE_WORDS - 1))
                    MemA <= word_addr(fill_base, rx_cnt[IDX_W-1:0] + idx_t'(1));
            end
            if (cmd == CMD_WORD)
                wr_cnt <= wr_cnt + idx_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_flush <= 1'b0;
            pend_inv   <= 1'b0;
            pend_inv_a <= '0;
            pend_snp   <= 1'b0;
            pend_snp_a <= '0;
            pend_snp_d <= '0;
            pend_snp_m <= '0;
        end else begin
            if (cmd == CMD_FLUSH)
                pend_flush <= 1'b0;
            else if (FlushReq)
                pend_flush <= 1'b1;

            if (cmd == CMD_INV) begin
                pend_inv   <= pend_inv & InvReq;
                pend_inv_a <= InvA;
            end else if (InvReq && !pend_inv) begin
                pend_inv   <= 1'b1;
                pend_inv_a <= InvA;
            end

            if (cmd == CMD_SNOOP) begin
                pend_snp   <= pend_snp & SnpWR;
                pend_snp_a <= SnpA;
                pend_snp_d <= SnpD;
                pend_snp_m <= SnpM;
            end else if (SnpWR && !pend_snp) begin
                pend_snp   <= 1'b1;
                pend_snp_a <= SnpA;
                pend_snp_d <= SnpD;
                pend_snp_m <= SnpM;
            end
        end
    end

    l2_fill_buf u_buf (
        .clk       (CLK),
        .rst_n     (nRST),
        .clear     (buf_clear),
        .load      (ack_ok),
        .load_data (MemD),
        .drain     (cmd == CMD_WORD),
        .excl_set  (excl_set),
        .excl_idx  (snp_a[IDX_W-1:0]),
        .excl_mask (snp_m),
        .rd_idx    (wr_cnt),
        .full      (buf_full),
        .data      (buf_data),
        .mask      (buf_mask)
    );

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Directed bench for l2_fill_ctrl: stimulus pushes the expected cache-port events into a queue,
// and a negedge monitor pops and compares one entry whenever WR, CLR or MissAck is strobed.
module tb_l2_fill_ctrl;

    localparam int K_WRITE = 0;
    localparam int K_CLEAR = 1;
    localparam int K_ACK   = 2;

    typedef struct {
        int          kind;
        logic [25:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        ts;
        logic        all;
    } exp_t;

    logic        CLK;
    logic        nRST;
    logic        MissReq;
    logic [27:2] MissA;
    logic        MissAck;
    logic        MemReq;
    logic [27:2] MemA;
    logic        MemAck;
    logic [31:0] MemD;
    logic        SnpWR;
    logic [27:2] SnpA;
    logic [31:0] SnpD;
    logic [3:0]  SnpM;
    logic        InvReq;
    logic [27:2] InvA;
    logic        FlushReq;
    logic [27:2] WRA;
    logic [31:0] WRD;
    logic [3:0]  WRM;
    logic        TS;
    logic        WR;
    logic        CLR;
    logic        ALL;
    logic        Busy;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    l2_fill_ctrl dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .MissReq  (MissReq),
        .MissA    (MissA),
        .MissAck  (MissAck),
        .MemReq   (MemReq),
        .MemA     (MemA),
        .MemAck   (MemAck),
        .MemD     (MemD),
        .SnpWR    (SnpWR),
        .SnpA     (SnpA),
        .SnpD     (SnpD),
        .SnpM     (SnpM),
        .InvReq   (InvReq),
        .InvA     (InvA),
        .FlushReq (FlushReq),
        .WRA      (WRA),
        .WRD      (WRD),
        .WRM      (WRM),
        .TS       (TS),
        .WR       (WR),
        .CLR      (CLR),
        .ALL      (ALL),
        .Busy     (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushWrite(input logic [25:0] a, input logic [31:0] d, input logic [3:0] m, input logic ts);
        sb.push_back('{kind: K_WRITE, addr: a, data: d, mask: m, ts: ts, all: 1'b0});
    endtask

    task automatic pushClear(input logic [25:0] a, input logic all);
        sb.push_back('{kind: K_CLEAR, addr: a, data: 32'h0, mask: 4'h0, ts: 1'b0, all: all});
    endtask

    task automatic pushAck();
        sb.push_back('{kind: K_ACK, addr: 26'h0, data: 32'h0, mask: 4'h0, ts: 1'b0, all: 1'b0});
    endtask

    task automatic applyStimulus(input logic flush, input logic inv, input logic [25:0] inva,
                                 input logic snp, input logic [25:0] snpa,
                                 input logic [31:0] snpd, input logic [3:0] snpm);
        FlushReq = flush;
        InvReq   = inv;
        InvA     = inva;
        SnpWR    = snp;
        SnpA     = snpa;
        SnpD     = snpd;
        SnpM     = snpm;
    endtask

    task automatic clearPulses();
        FlushReq = 1'b0;
        InvReq   = 1'b0;
        SnpWR    = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {25'h0, MissAck, MemReq, TS, WR, CLR, ALL, Busy}, 32'h0);
        checkOutput({tag, "_MemA"}, MemA, 32'h0);
        checkOutput({tag, "_WRA"}, WRA, 32'h0);
        checkOutput({tag, "_WRD"}, WRD, 32'h0);
        checkOutput({tag, "_WRM"}, WRM, 32'h0);
    endtask

    task automatic startMiss(input logic [25:0] a, input logic [25:0] base);
        MissReq = 1'b1;
        MissA   = a;
        tick();
        checkOutput("MemReq_on", MemReq, 1);
        checkOutput("MemA_base", MemA, base);
        checkOutput("Busy_fill", Busy, 1);
    endtask

    task automatic memBeat(input logic [25:0] a, input logic [31:0] d, input logic [3:0] m, input logic ts);
        checkOutput("MemA_beat", MemA, a);
        pushWrite(a, d, m, ts);
        MemAck = 1'b1;
        MemD   = d;
        tick();
        MemAck = 1'b0;
        tick();
    endtask

    task automatic finishMiss();
        bit seen;
        seen = 1'b0;
        pushAck();
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = MissAck;
        end
        if (!seen)
            checkOutput("MissAck_timeout", MissAck, 1);
        MissReq = 1'b0;
        tick();
        checkOutput("Busy_done", Busy, 0);
        checkOutput("MemReq_done", MemReq, 0);
    endtask

    task automatic checkEvent(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("unexpected_strobe", {29'h0, WR, CLR, MissAck}, 32'h0);
            return;
        end
        e = sb.pop_front();
        checkOutput("event_kind", k, e.kind);
        if (k == K_WRITE) begin
            checkOutput("WRA", WRA, e.addr);
            checkOutput("WRD", WRD, e.data);
            checkOutput("WRM", WRM, e.mask);
            checkOutput("TS", TS, e.ts);
        end else if (k == K_CLEAR) begin
            checkOutput("ALL", ALL, e.all);
            if (!e.all)
                checkOutput("CLR_WRA", WRA, e.addr);
        end
    endtask

    // Monitor: compares every cache-port strobe and MissAck pulse against the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1) begin
                if (WR || CLR)
                    checkEvent(WR ? K_WRITE : K_CLEAR);
                if (MissAck)
                    checkEvent(K_ACK);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        MissReq  = 1'b0;
        MissA    = '0;
        MemAck   = 1'b0;
        MemD     = '0;
        clearPulses();
        SnpA     = '0;
        SnpD     = '0;
        SnpM     = '0;
        InvA     = '0;
        #3;
        checkAllZero("reset");
        tick();
        tick();
        #2;
        nRST = 1'b1;
        tick();

        $display("[TB] plain fill");
        startMiss(26'h0001230, 26'h0001230);
        memBeat(26'h0001230, 32'hA000_0000, 4'hF, 1'b1);
        memBeat(26'h0001231, 32'hA111_1111, 4'hF, 1'b0);
        memBeat(26'h0001232, 32'hA222_2222, 4'hF, 1'b0);
        memBeat(26'h0001233, 32'hA333_3333, 4'hF, 1'b0);
        finishMiss();

        $display("[TB] snoop to word 2 before it arrives");
        startMiss(26'h0045670, 26'h0045670);
        memBeat(26'h0045670, 32'hB000_0000, 4'hF, 1'b1);
        memBeat(26'h0045671, 32'hB111_1111, 4'hF, 1'b0);
        pushWrite(26'h0045672, 32'hCAFE_F00D, 4'b0011, 1'b0);
        applyStimulus(1'b0, 1'b0, 26'h0, 1'b1, 26'h0045672, 32'hCAFE_F00D, 4'b0011);
        tick();
        clearPulses();
        tick();
        memBeat(26'h0045672, 32'hB222_2222, 4'b1100, 1'b0);
        memBeat(26'h0045673, 32'hB333_3333, 4'hF, 1'b0);
        finishMiss();

        $display("[TB] snoop racing memory beats");
        startMiss(26'h0100000, 26'h0100000);
        memBeat(26'h0100000, 32'hC000_0000, 4'hF, 1'b1);
        checkOutput("MemA_w1", MemA, 26'h0100001);
        pushWrite(26'h0200005, 32'h5A5A_5A5A, 4'b1010, 1'b0);
        pushWrite(26'h0100001, 32'hC111_1111, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b0, 26'h0, 1'b1, 26'h0200005, 32'h5A5A_5A5A, 4'b1010);
        MemAck = 1'b1;
        MemD   = 32'hC111_1111;
        tick();
        clearPulses();
        MemAck = 1'b0;
        tick();
        checkOutput("MemA_w2", MemA, 26'h0100002);
        MemAck = 1'b1;
        MemD   = 32'hC222_2222;
        tick();
        MemAck = 1'b0;
        pushWrite(26'h0100002, 32'h1234_5678, 4'b1000, 1'b0);
        pushWrite(26'h0100002, 32'hC222_2222, 4'b0111, 1'b0);
        applyStimulus(1'b0, 1'b0, 26'h0, 1'b1, 26'h0100002, 32'h1234_5678, 4'b1000);
        tick();
        clearPulses();
        tick();
        memBeat(26'h0100003, 32'hC333_3333, 4'hF, 1'b0);
        finishMiss();

        $display("[TB] flush aborts a fill");
        startMiss(26'h0333330, 26'h0333330);
        memBeat(26'h0333330, 32'hD000_0000, 4'hF, 1'b1);
        memBeat(26'h0333331, 32'hD111_1111, 4'hF, 1'b0);
        pushClear(26'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 26'h0, 1'b0, 26'h0, 32'h0, 4'h0);
        MissReq = 1'b0;
        tick();
        clearPulses();
        checkOutput("MemReq_abort", MemReq, 0);
        checkOutput("Busy_abort", Busy, 0);
        tick();
        tick();
        checkOutput("Busy_after_abort", Busy, 0);

        $display("[TB] reset during a fill");
        startMiss(26'h0055550, 26'h0055550);
        memBeat(26'h0055550, 32'hE000_0000, 4'hF, 1'b1);
        memBeat(26'h0055551, 32'hE111_1111, 4'hF, 1'b0);
        MemAck = 1'b1;
        MemD   = 32'hE222_2222;
        tick();
        MemAck  = 1'b0;
        MissReq = 1'b0;
        nRST    = 1'b0;
        #1;
        checkAllZero("midreset");
        #2;
        nRST = 1'b1;
        tick();
        startMiss(26'h0055550, 26'h0055550);
        memBeat(26'h0055550, 32'hF000_0000, 4'hF, 1'b1);
        memBeat(26'h0055551, 32'hF111_1111, 4'hF, 1'b0);
        memBeat(26'h0055552, 32'hF222_2222, 4'hF, 1'b0);
        memBeat(26'h0055553, 32'hF333_3333, 4'hF, 1'b0);
        finishMiss();

        $display("[TB] invalidate, snoop and miss together");
        pushClear(26'h0777771, 1'b0);
        pushWrite(26'h0888882, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        applyStimulus(1'b0, 1'b1, 26'h0777771, 1'b1, 26'h0888882, 32'hDEAD_BEEF, 4'b0101);
        MissReq = 1'b1;
        MissA   = 26'h0999993;
        tick();
        clearPulses();
        checkOutput("MemReq_after_inv", MemReq, 0);
        tick();
        checkOutput("MemReq_after_snp", MemReq, 0);
        tick();
        checkOutput("MemReq_third", MemReq, 1);
        checkOutput("MemA_third", MemA, 26'h0999990);
        memBeat(26'h0999990, 32'h9000_0000, 4'hF, 1'b1);
        memBeat(26'h0999991, 32'h9111_1111, 4'hF, 1'b0);
        memBeat(26'h0999992, 32'h9222_2222, 4'hF, 1'b0);
        memBeat(26'h0999993, 32'h9333_3333, 4'hF, 1'b0);
        finishMiss();

        tick();
        tick();
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
